net_loopback_delay: RTL and testbench

Parametrised AXI-stream network loopback emulator for the SGD bandwidth simulation environment; replaces the fixed 5000-stage shift-register loopback between the engine TX port and RX port. Each accepted beat is stored in a timestamped FIFO. The beat is released after a runtime-programmable delay, and both sides honour valid/ready backpressure. Optionally, whole packets are dropped periodically to exercise loss handling in the distributed SGD logic.

---
 rtl/net_loopback_delay_if.sv | 14 +
 rtl/net_loopback_delay.sv | 148 ++++++++++++++
 tb/tb_net_loopback_delay.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/net_loopback_delay_if.sv
// One AXI-stream link (data/keep/last/valid/ready) used for both ingress and egress
// of the network loopback emulator.
interface net_loopback_delay_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (output data, keep, last, valid, input ready);
    modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/net_loopback_delay.sv
// Network loopback emulator: timestamped FIFO that releases each beat D cycles after acceptance.
// Periodic whole-packet dropping is compiled in only when NET_LOOPBACK_DROP_EN is defined.
module net_loopback_delay #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 8192,
    parameter int TS_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TS_W-1:0]        delay_cycles,
    input  logic [15:0]            drop_every,
    net_loopback_delay_if.slave    s_axis,
    net_loopback_delay_if.master   m_axis,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            dropped_pkts
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int ENT_W  = DATA_WIDTH + KEEP_W + 1 + TS_W;
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TS_W-1:0] ONE_TS   = {{(TS_W-1){1'b0}}, 1'b1};

    logic [ENT_W-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           mem_cnt;
    logic [TS_W-1:0]       now;
    logic [TS_W-1:0]       d_q;
    logic [TS_W-1:0]       d_eff;
    logic [TS_W-1:0]       age;
    logic                  run_q;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [KEEP_W-1:0]     keep_p1;
    logic                  last_p1;
    logic [TS_W-1:0]       ts_p1;

    logic s_ready;
    logic m_valid;
    logic accept;
    logic push;
    logic pop;
    logic head_free;
    logic load_mem;
    logic load_byp;
    logic mem_wr;
    logic drop_beat;

    // The head register is part of the buffered count, so capacity is DEPTH in total.
    assign fifo_count = mem_cnt + {{AW{1'b0}}, vld_p1};
    assign s_ready    = run_q && (fifo_count < FULL_CNT);
    assign accept     = s_axis.valid && s_ready;
    assign push       = accept && !drop_beat;

    assign d_eff   = (d_q == '0) ? ONE_TS : d_q;
    assign age     = now - ts_p1;
    assign m_valid = vld_p1 && (age >= d_eff);
    assign pop     = m_valid && m_axis.ready;

    // Refill the head from memory first; bypass only when memory is empty, which keeps order.
    assign head_free = !vld_p1 || pop;
    assign load_mem  = head_free && (mem_cnt != '0);
    assign load_byp  = head_free && (mem_cnt == '0) && push;
    assign mem_wr    = push && !load_byp;

    assign s_axis.ready = s_ready;
    assign m_axis.valid = m_valid;
    assign m_axis.data  = m_valid ? data_p1 : '0;
    assign m_axis.keep  = m_valid ? keep_p1 : '0;
    assign m_axis.last  = m_valid && last_p1;

    always_ff @(posedge clk) begin
        d_q <= delay_cycles;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            vld_p1  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            now   <= now + 1'b1;
            run_q <= 1'b1;
            if (mem_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (load_mem)
                rd_ptr <= rd_ptr + 1'b1;
            mem_cnt <= mem_cnt + (AW+1)'(mem_wr) - (AW+1)'(load_mem);
            if (head_free)
                vld_p1 <= load_mem || load_byp;
        end
    end

    // Stage p0: timestamped storage
    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr] <= {s_axis.data, s_axis.keep, s_axis.last, now};
    end

    // Stage p1: prefetched head entry driving the egress port
    always_ff @(posedge clk) begin
        if (load_mem)
            {data_p1, keep_p1, last_p1, ts_p1} <= mem[rd_ptr];
        else if (load_byp)
            {data_p1, keep_p1, last_p1, ts_p1} <= {s_axis.data, s_axis.keep, s_axis.last, now};
    end

`ifdef NET_LOOPBACK_DROP_EN
    logic [31:0] pkt_n;
    logic [31:0] dropped_q;
    logic        in_pkt_q;
    logic        drop_pkt_q;
    logic        drop_now;

    // Drop decision is taken on a packet's first beat and latched for the rest of it.
    assign drop_now     = (drop_every != 16'd0) &&
                          (((pkt_n + 32'd1) % {16'd0, drop_every}) == 32'd0);
    assign drop_beat    = in_pkt_q ? drop_pkt_q : drop_now;
    assign dropped_pkts = dropped_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_n      <= '0;
            dropped_q  <= '0;
            in_pkt_q   <= 1'b0;
            drop_pkt_q <= 1'b0;
        end else if (accept) begin
            in_pkt_q <= !s_axis.last;
            if (!in_pkt_q)
                drop_pkt_q <= drop_now;
            if (s_axis.last) begin
                pkt_n <= pkt_n + 32'd1;
                if (drop_beat)
                    dropped_q <= dropped_q + 32'd1;
            end
        end
    end
`else
    logic unused_drop_every;
    assign unused_drop_every = ^drop_every;
    assign drop_beat         = 1'b0;
    assign dropped_pkts      = '0;
`endif
endmodule

// File: tb/tb_net_loopback_delay.sv
// Randomized bench for net_loopback_delay, checked every cycle against a queue-based
// model in which a beat accepted at edge k is releasable once (last edge - k + 1) >= max(D,1).
module tb_net_loopback_delay;
    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 128;
    localparam int TS_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [TS_W-1:0]         delay_cycles;
    logic [15:0]             drop_every;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [31:0]             dropped_pkts;

    net_loopback_delay_if #(.DATA_WIDTH(DW)) s_if ();
    net_loopback_delay_if #(.DATA_WIDTH(DW)) m_if ();

    net_loopback_delay #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .delay_cycles (delay_cycles),
        .drop_every   (drop_every),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .fifo_count   (fifo_count),
        .dropped_pkts (dropped_pkts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int unsigned   k;
    } beat_t;

    beat_t           q[$];
    int unsigned     e = 0;
    logic [TS_W-1:0] d_last = '0;
    bit              run = 1'b0;
    bit              released = 1'b0;
    int unsigned     pkt_n = 0;
    int unsigned     n_dropped = 0;
    bit              in_pkt = 1'b0;
    bit              drop_cur = 1'b0;
    int              errors = 0;
    int              checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, act, exp);
        end
    endtask

    function automatic bit exp_mvalid();
        int unsigned d;
        d = (d_last == '0) ? 1 : int'(d_last);
        if (q.size() == 0) return 1'b0;
        return (e - q[0].k + 1) >= d;
    endfunction

    // Drive one cycle, advance the model at the edge, then compare at the falling edge.
    task automatic cycle(input bit v, input logic [DW-1:0] dat, input bit l, input bit r);
        logic [KW-1:0] kp;
        bit acc, pop, drop, ev;
        kp          = KW'($urandom);
        s_if.data   = dat;
        s_if.keep   = kp;
        s_if.last   = l;
        s_if.valid  = v;
        m_if.ready  = r;
        acc = v && run && (q.size() < DEPTH);
        pop = exp_mvalid() && r;
        @(posedge clk);
        e++;
        if (!rst_n) begin
            q.delete();
            run = 1'b0; released = 1'b0;
            pkt_n = 0; n_dropped = 0; in_pkt = 1'b0; drop_cur = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                drop = 1'b0;
`ifdef NET_LOOPBACK_DROP_EN
                if (!in_pkt)
                    drop_cur = (drop_every != 0) && (((pkt_n + 1) % drop_every) == 0);
                drop = drop_cur;
                if (l) begin
                    pkt_n++;
                    if (drop) n_dropped++;
                end
                in_pkt = !l;
`endif
                if (!drop) q.push_back('{data: dat, keep: kp, last: l, k: e});
            end
            run = 1'b1;
        end
        d_last = delay_cycles;
        @(negedge clk);
        ev = exp_mvalid();
        check("s_ready", 64'(s_if.ready), 64'(run && (q.size() < DEPTH)));
        check("m_valid", 64'(m_if.valid), 64'(ev));
        check("fifo_count", 64'(fifo_count), 64'(q.size()));
        check("dropped_pkts", 64'(dropped_pkts), 64'(n_dropped));
        if (ev) begin
            check("m_data", 64'(m_if.data), 64'(q[0].data));
            check("m_keep", 64'(m_if.keep), 64'(q[0].keep));
            check("m_last", 64'(m_if.last), 64'(q[0].last));
            released = 1'b1;
        end else if (!released) begin
            check("m_data_idle", 64'(m_if.data), 64'd0);
            check("m_last_idle", 64'(m_if.last), 64'd0);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, r);
    endtask

    initial begin
        delay_cycles = 5;
        drop_every   = 16'd0;
        s_if.data = '0; s_if.keep = '0; s_if.last = 1'b0; s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        #1;

        // reset state
        rst_n = 1'b0;
        idle(3, 1'b1);
        rst_n = 1'b1;

        // single beat 0xA5 with D=5
        idle(6, 1'b1);
        cycle(1'b1, 32'hA5, 1'b1, 1'b1);
        idle(10, 1'b1);

        // D=100, 64 back-to-back beats
        delay_cycles = 100;
        idle(2, 1'b1);
        for (int i = 0; i < 64; i++) cycle(1'b1, $urandom, (i % 4) == 3, 1'b1);
        idle(110, 1'b1);

        // fill to DEPTH with egress stalled, then drain
        delay_cycles = 1;
        for (int i = 0; i < DEPTH + 10; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
        idle(DEPTH + 10, 1'b1);

        // long delay shortened while beats wait
        delay_cycles = 1000;
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b1, 1'b1);
        idle(20, 1'b1);
        delay_cycles = 10;
        idle(20, 1'b1);

        // periodic packet drop: 9 three-beat packets, every third dropped when enabled
        rst_n = 1'b0;
        idle(2, 1'b1);
        rst_n = 1'b1;
        delay_cycles = 4;
        drop_every   = 16'd3;
        for (int p = 0; p < 9; p++)
            for (int b = 0; b < 3; b++) cycle(1'b1, $urandom, b == 2, 1'b1);
        idle(30, 1'b1);
`ifdef NET_LOOPBACK_DROP_EN
        check("drop_total", 64'(dropped_pkts), 64'd3);
`else
        check("drop_total", 64'(dropped_pkts), 64'd0);
`endif

        // randomized traffic with changing delay, drop period and backpressure
        for (int i = 0; i < 2000; i++) begin
            if ((i % 50) == 0) delay_cycles = $urandom_range(0, 12);
            if ((i % 170) == 0) drop_every = 16'($urandom_range(0, 4));
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 6);
        end
        drop_every = 16'd0;
        idle(40, 1'b1);

        // reset mid-packet with beats buffered, then a clean packet
        delay_cycles = 50;
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
        rst_n = 1'b0;
        cycle(1'b1, $urandom, 1'b0, 1'b1);
        rst_n = 1'b1;
        delay_cycles = 6;
        idle(1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, i == 2, 1'b1);
        idle(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
